// File: rtl/riscv_multicycle_if.sv
// Shared memory port of the multi-cycle core: one request at a time, req/ack handshake.
interface riscv_multicycle_if #(
    parameter int XLEN     = 64,
    parameter int ADDRSIZE = 8
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     mem_rdata;
    logic                mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/riscv_multicycle.sv
// Multi-cycle RV64I-subset core (add/sub/and/or/addi/ld/sd/beq) over a single
// req/ack memory port; illegal opcodes park the core in a sticky halt.
module riscv_multicycle #(
    parameter int XLEN     = 64,
    parameter int ADDRSIZE = 8,
    parameter int RESET_PC = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    riscv_multicycle_if.master  mem,
    output logic [ADDRSIZE-1:0] pc_o,
    output logic                retire_o,
    output logic                halted_o
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_SD, OP_BEQ} op_e;

    localparam logic [ADDRSIZE-1:0] PC_INIT = ADDRSIZE'(RESET_PC);
    localparam logic [ADDRSIZE-1:0] PC_STEP = ADDRSIZE'(3'd4);

    state_e              state_q, state_d;
    op_e                 op_q, op_s;
    logic                illegal_s;
    logic [31:0]         ir_q;
    logic [XLEN-1:0]     a_q, b_q, imm_q, res_q;
    logic [XLEN-1:0]     imm_s, opnd_s, alu_s;
    logic [XLEN-1:0]     rf_q [32];
    logic [ADDRSIZE-1:0] pc_q, addr_q, pc_plus4_s, br_tgt_s;
    logic [XLEN-1:0]     wdata_q;
    logic                req_q, we_q, retire_q, halted_q, ack_s;

    assign ack_s      = req_q & mem.mem_ack;
    assign pc_plus4_s = pc_q + PC_STEP;
    assign br_tgt_s   = pc_q + imm_q[ADDRSIZE-1:0];

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign pc_o          = pc_q;
    assign retire_o      = retire_q;
    assign halted_o      = halted_q;

    // Instruction decode: operation class, legality and sign-extended immediate
    always_comb begin
        op_s      = OP_ADD;
        illegal_s = 1'b0;
        imm_s     = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        case (ir_q[6:0])
            7'b0110011: begin
                if (ir_q[14:12] == 3'b000 && ir_q[31:25] == 7'b0000000) begin
                    op_s = OP_ADD;
                end else if (ir_q[14:12] == 3'b000 && ir_q[31:25] == 7'b0100000) begin
                    op_s = OP_SUB;
                end else if (ir_q[14:12] == 3'b111 && ir_q[31:25] == 7'b0000000) begin
                    op_s = OP_AND;
                end else if (ir_q[14:12] == 3'b110 && ir_q[31:25] == 7'b0000000) begin
                    op_s = OP_OR;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            7'b0010011: begin
                if (ir_q[14:12] == 3'b000) op_s = OP_ADDI;
                else                       illegal_s = 1'b1;
            end
            7'b0000011: begin
                if (ir_q[14:12] == 3'b011) op_s = OP_LD;
                else                       illegal_s = 1'b1;
            end
            7'b0100011: begin
                if (ir_q[14:12] == 3'b011) begin
                    op_s  = OP_SD;
                    imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
                end else begin
                    illegal_s = 1'b1;
                end
            end
            7'b1100011: begin
                if (ir_q[14:12] == 3'b000) begin
                    op_s  = OP_BEQ;
                    imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
                end else begin
                    illegal_s = 1'b1;
                end
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // ALU; loads and stores reuse the adder for rs1+imm
    always_comb begin
        opnd_s = (op_q inside {OP_ADDI, OP_LD, OP_SD}) ? imm_q : b_q;
        case (op_q)
            OP_SUB:  alu_s = a_q - b_q;
            OP_AND:  alu_s = a_q & b_q;
            OP_OR:   alu_s = a_q | b_q;
            default: alu_s = a_q + opnd_s;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = ack_s ? S_DECODE : S_FETCH;
            S_DECODE: state_d = illegal_s ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (op_q == OP_BEQ)                          state_d = S_FETCH;
                else if (op_q == OP_LD || op_q == OP_SD)     state_d = S_MEM;
                else                                         state_d = S_WB;
            end
            S_MEM: begin
                if (ack_s) state_d = (op_q == OP_LD) ? S_WB : S_FETCH;
                else       state_d = S_MEM;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Datapath, register file and memory-port registers; the next fetch is
    // issued on the same edge an instruction retires so zero-wait fetch costs one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= PC_INIT;
            ir_q     <= 32'd0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            res_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= pc_q;
                    end else if (ack_s) begin
                        ir_q  <= mem.mem_rdata[31:0];
                        req_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    a_q      <= rf_q[ir_q[19:15]];
                    b_q      <= rf_q[ir_q[24:20]];
                    imm_q    <= imm_s;
                    op_q     <= op_s;
                    halted_q <= illegal_s;
                end
                S_EXEC: begin
                    if (op_q == OP_BEQ) begin
                        pc_q     <= (a_q == b_q) ? br_tgt_s : pc_plus4_s;
                        addr_q   <= (a_q == b_q) ? br_tgt_s : pc_plus4_s;
                        req_q    <= 1'b1;
                        we_q     <= 1'b0;
                        retire_q <= 1'b1;
                    end else if (op_q == OP_LD || op_q == OP_SD) begin
                        req_q  <= 1'b1;
                        we_q   <= (op_q == OP_SD);
                        addr_q <= alu_s[ADDRSIZE-1:0];
                        if (op_q == OP_SD) wdata_q <= b_q;
                    end else begin
                        res_q <= alu_s;
                    end
                end
                S_MEM: begin
                    if (ack_s && op_q == OP_LD) begin
                        res_q <= mem.mem_rdata;
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                    end else if (ack_s) begin
                        pc_q     <= pc_plus4_s;
                        addr_q   <= pc_plus4_s;
                        we_q     <= 1'b0;
                        retire_q <= 1'b1;
                    end
                end
                S_WB: begin
                    if (ir_q[11:7] != 5'd0) rf_q[ir_q[11:7]] <= res_q;
                    pc_q     <= pc_plus4_s;
                    addr_q   <= pc_plus4_s;
                    req_q    <= 1'b1;
                    we_q     <= 1'b0;
                    retire_q <= 1'b1;
                end
                S_HALT: begin
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                end
                default: req_q <= 1'b0;
            endcase
        end
    end
endmodule
